multicycle_controller: RTL and testbench

- Multi-cycle control FSM that sequences the shared CPU datapath (PC, IR, register file, ALU, unified instruction/data memory) one state per cycle.
- Supports the core subset: add, jr, syscall, jal, beq, bne, addi, addiu, slti, lw, sw.
- Adds a memory ready handshake with a timeout, and a halt/fault status for the testbench.

---
 rtl/mc_pkg.sv | 91 +++++++++
 rtl/multicycle_controller_mem_wait_timer.sv | 41 ++++
 rtl/multicycle_controller.sv | 208 ++++++++++++++++++++
 tb/tb_multicycle_controller.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_pkg.sv
// -----------------------------------------------------------------------------
// mc_pkg
// Shared definitions for the multi-cycle controller: instruction opcode and
// funct constants, the controller state enum, the datapath mux/ALU encodings
// and small decode helpers used by DECODE.
// -----------------------------------------------------------------------------
package mc_pkg;

    // Opcodes (IR[31:26])
    localparam logic [5:0] OP_R     = 6'd0;
    localparam logic [5:0] OP_JAL   = 6'd3;
    localparam logic [5:0] OP_BEQ   = 6'd4;
    localparam logic [5:0] OP_BNE   = 6'd5;
    localparam logic [5:0] OP_ADDI  = 6'd8;
    localparam logic [5:0] OP_ADDIU = 6'd9;
    localparam logic [5:0] OP_SLTI  = 6'd10;
    localparam logic [5:0] OP_LW    = 6'd35;
    localparam logic [5:0] OP_SW    = 6'd43;

    // R-type funct codes (IR[5:0])
    localparam logic [5:0] FN_JR      = 6'd8;
    localparam logic [5:0] FN_SYSCALL = 6'd12;
    localparam logic [5:0] FN_ADD     = 6'd32;

    typedef enum logic [3:0] {
        ST_FETCH  = 4'd0,
        ST_DECODE = 4'd1,
        ST_EXEC   = 4'd2,
        ST_ADDR   = 4'd3,
        ST_MEM    = 4'd4,
        ST_WB     = 4'd5,
        ST_BRANCH = 4'd6,
        ST_JUMP   = 4'd7,
        ST_HALT   = 4'd8,
        ST_FAULT  = 4'd9
    } state_t;

    // pc_src
    localparam logic [1:0] PC_ALU    = 2'd0;
    localparam logic [1:0] PC_RS     = 2'd1;
    localparam logic [1:0] PC_JUMP   = 2'd2;
    localparam logic [1:0] PC_BRANCH = 2'd3;

    // alu_src_b
    localparam logic [1:0] ALUB_RT   = 2'd0;
    localparam logic [1:0] ALUB_FOUR = 2'd1;
    localparam logic [1:0] ALUB_SIMM = 2'd2;
    localparam logic [1:0] ALUB_ZIMM = 2'd3;

    // alu_cmd
    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd2;
    localparam logic [2:0] ALU_SLT = 3'd3;

    // reg_dst
    localparam logic [1:0] RD_RD = 2'd0;
    localparam logic [1:0] RD_RT = 2'd1;
    localparam logic [1:0] RD_RA = 2'd2;

    // wb_src
    localparam logic [1:0] WB_ALU = 2'd0;
    localparam logic [1:0] WB_MEM = 2'd1;
    localparam logic [1:0] WB_PC  = 2'd2;

    // True when opcode/funct is part of the supported subset.
    function automatic logic is_legal(input logic [5:0] op, input logic [5:0] fn);
        case (op)
            OP_R:    is_legal = (fn == FN_JR) || (fn == FN_SYSCALL) || (fn == FN_ADD);
            OP_JAL, OP_BEQ, OP_BNE, OP_ADDI, OP_ADDIU, OP_SLTI, OP_LW, OP_SW:
                     is_legal = 1'b1;
            default: is_legal = 1'b0;
        endcase
    endfunction

    // State following DECODE for a legal instruction.
    function automatic state_t legal_next(input logic [5:0] op, input logic [5:0] fn);
        case (op)
            OP_R: begin
                if (fn == FN_JR)           legal_next = ST_JUMP;
                else if (fn == FN_SYSCALL) legal_next = ST_HALT;
                else                       legal_next = ST_EXEC;
            end
            OP_JAL:                        legal_next = ST_JUMP;
            OP_BEQ, OP_BNE:                legal_next = ST_BRANCH;
            OP_ADDI, OP_ADDIU, OP_SLTI:    legal_next = ST_EXEC;
            OP_LW, OP_SW:                  legal_next = ST_ADDR;
            default:                       legal_next = ST_FETCH;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_controller_mem_wait_timer.sv
// -----------------------------------------------------------------------------
// mem_wait_timer
// Counts consecutive cycles a memory request has been left unanswered and
// flags when the count reaches MEM_TIMEOUT. MEM_TIMEOUT = 0 disables it.
// Ports: clk, rst_n (sync active-low), waiting (request pending, not ready),
//        clear (request finished or not in a memory state), expired.
// -----------------------------------------------------------------------------
module mem_wait_timer #(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic waiting,
    input  logic clear,
    output logic expired
);
    localparam int            CW      = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);
    localparam logic [CW-1:0] C_LIMIT = CW'(MEM_TIMEOUT);
    localparam logic [CW-1:0] C_SAT   = {CW{1'b1}};
    localparam logic [CW-1:0] C_ONE   = CW'(1);
    localparam logic [CW-1:0] C_ZERO  = {CW{1'b0}};
    localparam bit            EN      = (MEM_TIMEOUT != 0);

    logic [CW-1:0] r_cnt;

    // Saturating count of not-ready cycles in the current memory state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt <= C_ZERO;
        end else if (clear) begin
            r_cnt <= C_ZERO;
        end else if (waiting && (r_cnt != C_SAT)) begin
            r_cnt <= r_cnt + C_ONE;
        end else begin
            r_cnt <= r_cnt;
        end
    end

    assign expired = EN && (r_cnt == C_LIMIT);

endmodule

// File: rtl/multicycle_controller.sv
// -----------------------------------------------------------------------------
// multicycle_controller
// Control FSM for a shared-datapath multi-cycle CPU (add, jr, syscall, jal,
// beq, bne, addi, addiu, slti, lw, sw), one state per cycle, with a memory
// ready handshake guarded by a timeout and sticky halted/fault status.
// Inputs : clk, rst_n (sync active-low), opcode, funct, alu_zero, mem_ready.
// Outputs: mem_req, mem_we, iord, ir_we, pc_we, pc_src, alu_src_a,
//          alu_src_b, alu_cmd, reg_we, reg_dst, wb_src, halted, fault, state.
// Build option: define ILLEGAL_TRAP_EN to send unsupported instructions to
// FAULT; otherwise they retire as a NOP (DECODE -> FETCH).
// -----------------------------------------------------------------------------
module multicycle_controller
    import mc_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       alu_zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_we,
    output logic       iord,
    output logic       ir_we,
    output logic       pc_we,
    output logic [1:0] pc_src,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] alu_cmd,
    output logic       reg_we,
    output logic [1:0] reg_dst,
    output logic [1:0] wb_src,
    output logic       halted,
    output logic       fault,
    output logic [3:0] state
);
    state_t     r_state;
    state_t     w_next;
    logic [5:0] r_op_q;
    logic [5:0] r_funct_q;
    logic       r_halted;
    logic       r_fault;

    logic       w_waiting;
    logic       w_expired;

    logic       w_mem_req, w_mem_we, w_iord, w_ir_we, w_pc_we, w_alu_src_a, w_reg_we;
    logic [1:0] w_pc_src, w_alu_src_b, w_reg_dst, w_wb_src;
    logic [2:0] w_alu_cmd;

    // Any cycle that is not an unanswered memory request clears the timer,
    // which covers every exit from FETCH/MEM.
    assign w_waiting = ((r_state == ST_FETCH) || (r_state == ST_MEM)) && !mem_ready;

    mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .waiting (w_waiting),
        .clear   (!w_waiting),
        .expired (w_expired)
    );

    // Next-state selection; a ready response always beats a timeout match.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_FETCH: begin
                if (mem_ready)      w_next = ST_DECODE;
                else if (w_expired) w_next = ST_FAULT;
                else                w_next = ST_FETCH;
            end
            ST_DECODE: begin
                if (is_legal(opcode, funct)) begin
                    w_next = legal_next(opcode, funct);
                end else begin
`ifdef ILLEGAL_TRAP_EN
                    w_next = ST_FAULT;
`else
                    w_next = ST_FETCH;
`endif
                end
            end
            ST_EXEC:   w_next = ST_WB;
            ST_ADDR:   w_next = ST_MEM;
            ST_MEM: begin
                if (mem_ready)      w_next = (r_op_q == OP_LW) ? ST_WB : ST_FETCH;
                else if (w_expired) w_next = ST_FAULT;
                else                w_next = ST_MEM;
            end
            ST_WB:     w_next = ST_FETCH;
            ST_BRANCH: w_next = ST_FETCH;
            ST_JUMP:   w_next = ST_FETCH;
            ST_HALT:   w_next = ST_HALT;
            ST_FAULT:  w_next = ST_FAULT;
            default:   w_next = ST_FETCH;
        endcase
    end

    // State register, captured instruction fields and sticky status flags.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= ST_FETCH;
            r_op_q    <= 6'd0;
            r_funct_q <= 6'd0;
            r_halted  <= 1'b0;
            r_fault   <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == ST_DECODE) begin
                r_op_q    <= opcode;
                r_funct_q <= funct;
            end
            if (w_next == ST_HALT)  r_halted <= 1'b1;
            if (w_next == ST_FAULT) r_fault  <= 1'b1;
        end
    end

    // Per-state control decode; pc_we in BRANCH and FETCH/MEM handshake terms
    // are the only outputs that look at live inputs.
    always_comb begin
        w_mem_req   = 1'b0;
        w_mem_we    = 1'b0;
        w_iord      = 1'b0;
        w_ir_we     = 1'b0;
        w_pc_we     = 1'b0;
        w_pc_src    = PC_ALU;
        w_alu_src_a = 1'b0;
        w_alu_src_b = ALUB_RT;
        w_alu_cmd   = ALU_ADD;
        w_reg_we    = 1'b0;
        w_reg_dst   = RD_RD;
        w_wb_src    = WB_ALU;
        case (r_state)
            ST_FETCH: begin
                w_mem_req   = 1'b1;
                w_alu_src_b = ALUB_FOUR;
                w_ir_we     = mem_ready;
                w_pc_we     = mem_ready;
            end
            ST_EXEC: begin
                w_alu_src_a = 1'b1;
                case (r_op_q)
                    OP_ADDI:  w_alu_src_b = ALUB_SIMM;
                    OP_ADDIU: w_alu_src_b = ALUB_ZIMM;
                    OP_SLTI: begin
                        w_alu_src_b = ALUB_SIMM;
                        w_alu_cmd   = ALU_SLT;
                    end
                    default:  w_alu_src_b = ALUB_RT;
                endcase
            end
            ST_ADDR: begin
                w_alu_src_a = 1'b1;
                w_alu_src_b = ALUB_SIMM;
            end
            ST_MEM: begin
                w_mem_req = 1'b1;
                w_iord    = 1'b1;
                w_mem_we  = (r_op_q == OP_SW);
            end
            ST_WB: begin
                w_reg_we  = 1'b1;
                w_reg_dst = ((r_op_q == OP_R) && (r_funct_q == FN_ADD)) ? RD_RD : RD_RT;
                w_wb_src  = (r_op_q == OP_LW) ? WB_MEM : WB_ALU;
            end
            ST_BRANCH: begin
                w_alu_src_a = 1'b1;
                w_alu_cmd   = ALU_SUB;
                w_pc_src    = PC_BRANCH;
                w_pc_we     = ((r_op_q == OP_BEQ) && alu_zero) ||
                              ((r_op_q == OP_BNE) && !alu_zero);
            end
            ST_JUMP: begin
                w_pc_we = 1'b1;
                if (r_op_q == OP_JAL) begin
                    w_pc_src  = PC_JUMP;
                    w_reg_we  = 1'b1;
                    w_reg_dst = RD_RA;
                    w_wb_src  = WB_PC;
                end else begin
                    w_pc_src  = PC_RS;
                end
            end
            default: begin
            end
        endcase
    end

    // Hold every output low while reset is asserted.
    assign mem_req   = rst_n & w_mem_req;
    assign mem_we    = rst_n & w_mem_we;
    assign iord      = rst_n & w_iord;
    assign ir_we     = rst_n & w_ir_we;
    assign pc_we     = rst_n & w_pc_we;
    assign pc_src    = rst_n ? w_pc_src    : 2'd0;
    assign alu_src_a = rst_n & w_alu_src_a;
    assign alu_src_b = rst_n ? w_alu_src_b : 2'd0;
    assign alu_cmd   = rst_n ? w_alu_cmd   : 3'd0;
    assign reg_we    = rst_n & w_reg_we;
    assign reg_dst   = rst_n ? w_reg_dst   : 2'd0;
    assign wb_src    = rst_n ? w_wb_src    : 2'd0;
    assign halted    = rst_n & r_halted;
    assign fault     = rst_n & r_fault;
    assign state     = rst_n ? r_state     : 4'd0;

endmodule

// File: tb/tb_multicycle_controller.sv
// -----------------------------------------------------------------------------
// tb_multicycle_controller
// For each instruction the bench writes out the cycle-by-cycle control
// vector the controller must produce (from the instruction class, the memory
// wait schedule and the timeout rule), then replays that trace against the
// DUT, comparing every output on every cycle.
// -----------------------------------------------------------------------------
module tb_multicycle_controller;

    localparam int TO = 3;

    localparam int S_FETCH = 0, S_DECODE = 1, S_EXEC = 2, S_ADDR = 3, S_MEM = 4;
    localparam int S_WB = 5, S_BRANCH = 6, S_JUMP = 7, S_HALT = 8, S_FAULT = 9;

    localparam int K_ADD = 0, K_ADDI = 1, K_ADDIU = 2, K_SLTI = 3, K_LW = 4, K_SW = 5;
    localparam int K_BEQ = 6, K_BNE = 7, K_JR = 8, K_JAL = 9, K_SYS = 10, K_ILL = 11;

    typedef struct packed {
        logic [3:0] st;
        logic       mem_req, mem_we, iord, ir_we, pc_we;
        logic [1:0] pc_src;
        logic       asa;
        logic [1:0] asb;
        logic [2:0] cmd;
        logic       reg_we;
        logic [1:0] reg_dst, wb_src;
        logic       halted, fault;
    } outs_t;

    typedef struct packed {
        logic       rst_n, rdy, zero;
        logic [5:0] op, fn;
        outs_t      exp;
    } step_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] opcode = 6'd0, funct = 6'd0;
    logic       alu_zero = 1'b0, mem_ready = 1'b0;
    logic       mem_req, mem_we, iord, ir_we, pc_we, alu_src_a, reg_we, halted, fault;
    logic [1:0] pc_src, alu_src_b, reg_dst, wb_src;
    logic [2:0] alu_cmd;
    logic [3:0] state;

    int         n_cmp = 0;
    int         n_bad = 0;
    step_t      q[$];
    logic [5:0] cur_op, cur_fn;

    multicycle_controller #(.MEM_TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct),
        .alu_zero(alu_zero), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_we(mem_we), .iord(iord), .ir_we(ir_we),
        .pc_we(pc_we), .pc_src(pc_src), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_cmd(alu_cmd), .reg_we(reg_we),
        .reg_dst(reg_dst), .wb_src(wb_src), .halted(halted), .fault(fault),
        .state(state)
    );

    always #5 clk = ~clk;

    function automatic logic rb();
        return logic'($urandom_range(0, 1));
    endfunction

    function automatic outs_t base(input int s);
        outs_t o;
        o = '0;
        o.st = 4'(s);
        return o;
    endfunction

    function automatic int classify(input logic [5:0] op, input logic [5:0] fn);
        case (op)
            6'd0: begin
                if (fn == 6'd32)      return K_ADD;
                else if (fn == 6'd8)  return K_JR;
                else if (fn == 6'd12) return K_SYS;
                else                  return K_ILL;
            end
            6'd3:  return K_JAL;
            6'd4:  return K_BEQ;
            6'd5:  return K_BNE;
            6'd8:  return K_ADDI;
            6'd9:  return K_ADDIU;
            6'd10: return K_SLTI;
            6'd35: return K_LW;
            6'd43: return K_SW;
            default: return K_ILL;
        endcase
    endfunction

    task automatic push_step(input logic rdy, input logic zero, input bit use_ir, input outs_t o);
        step_t s;
        s.rst_n = 1'b1;
        s.rdy   = rdy;
        s.zero  = zero;
        s.op    = use_ir ? cur_op : 6'($urandom_range(0, 63));
        s.fn    = use_ir ? cur_fn : 6'($urandom_range(0, 63));
        s.exp   = o;
        q.push_back(s);
    endtask

    task automatic push_reset();
        step_t s;
        s.rst_n = 1'b0;
        s.rdy   = rb();
        s.zero  = rb();
        s.op    = 6'($urandom_range(0, 63));
        s.fn    = 6'($urandom_range(0, 63));
        s.exp   = base(S_FETCH);
        q.push_back(s);
    endtask

    task automatic fault_tail();
        outs_t o;
        o = base(S_FAULT);
        o.fault = 1'b1;
        for (int i = 0; i < 3; i++) push_step(rb(), rb(), 1'b0, o);
        push_reset();
    endtask

    // A request answered after `waits` idle cycles; times out once TO idle
    // cycles have already passed and the current one is idle too.
    task automatic mem_phase(input int st, input int waits, input logic we, output bit flt);
        outs_t o;
        logic  rdy;
        flt = 1'b0;
        for (int k = 0; k <= waits; k++) begin
            rdy = (k == waits);
            o = base(st);
            o.mem_req = 1'b1;
            if (st == S_FETCH) begin
                o.asb   = 2'd1;
                o.ir_we = rdy;
                o.pc_we = rdy;
            end else begin
                o.iord   = 1'b1;
                o.mem_we = we;
            end
            push_step(rdy, rb(), 1'b0, o);
            if ((k == TO) && !rdy) begin
                flt = 1'b1;
                break;
            end
        end
    endtask

    task automatic build(input logic [5:0] op, input logic [5:0] fn, input int wf,
                         input int wm, input logic zero, input int abort_at);
        int    start;
        int    k;
        bit    flt;
        outs_t o;
        start  = q.size();
        cur_op = op;
        cur_fn = fn;
        k      = classify(op, fn);
        mem_phase(S_FETCH, wf, 1'b0, flt);
        if (flt) begin
            fault_tail();
        end else begin
            push_step(rb(), rb(), 1'b1, base(S_DECODE));
            case (k)
                K_ADD, K_ADDI, K_ADDIU, K_SLTI: begin
                    o = base(S_EXEC);
                    o.asa = 1'b1;
                    o.asb = (k == K_ADD) ? 2'd0 : ((k == K_ADDIU) ? 2'd3 : 2'd2);
                    o.cmd = (k == K_SLTI) ? 3'd3 : 3'd0;
                    push_step(rb(), rb(), 1'b0, o);
                    o = base(S_WB);
                    o.reg_we  = 1'b1;
                    o.reg_dst = (k == K_ADD) ? 2'd0 : 2'd1;
                    push_step(rb(), rb(), 1'b0, o);
                end
                K_LW, K_SW: begin
                    o = base(S_ADDR);
                    o.asa = 1'b1;
                    o.asb = 2'd2;
                    push_step(rb(), rb(), 1'b0, o);
                    mem_phase(S_MEM, wm, (k == K_SW), flt);
                    if (flt) begin
                        fault_tail();
                    end else if (k == K_LW) begin
                        o = base(S_WB);
                        o.reg_we  = 1'b1;
                        o.reg_dst = 2'd1;
                        o.wb_src  = 2'd1;
                        push_step(rb(), rb(), 1'b0, o);
                    end
                end
                K_BEQ, K_BNE: begin
                    o = base(S_BRANCH);
                    o.asa    = 1'b1;
                    o.cmd    = 3'd2;
                    o.pc_src = 2'd3;
                    o.pc_we  = (k == K_BEQ) ? zero : !zero;
                    push_step(rb(), zero, 1'b0, o);
                end
                K_JR, K_JAL: begin
                    o = base(S_JUMP);
                    o.pc_we = 1'b1;
                    if (k == K_JAL) begin
                        o.pc_src  = 2'd2;
                        o.reg_we  = 1'b1;
                        o.reg_dst = 2'd2;
                        o.wb_src  = 2'd2;
                    end else begin
                        o.pc_src  = 2'd1;
                    end
                    push_step(rb(), rb(), 1'b0, o);
                end
                K_SYS: begin
                    o = base(S_HALT);
                    o.halted = 1'b1;
                    for (int i = 0; i < 20; i++) push_step(rb(), rb(), 1'b0, o);
                    push_reset();
                end
                default: begin
`ifdef ILLEGAL_TRAP_EN
                    fault_tail();
`endif
                end
            endcase
        end
        if ((abort_at > 0) && (q.size() - start > abort_at)) begin
            while (q.size() > start + abort_at) void'(q.pop_back());
            push_reset();
        end
    endtask

    function automatic string sname(input logic [3:0] s);
        case (s)
            4'd0: return "FETCH";   4'd1: return "DECODE"; 4'd2: return "EXEC";
            4'd3: return "ADDR";    4'd4: return "MEM";    4'd5: return "WB";
            4'd6: return "BRANCH";  4'd7: return "JUMP";   4'd8: return "HALT";
            4'd9: return "FAULT";   default: return "?";
        endcase
    endfunction

    task automatic check_int(input string name, input int got, input int want);
        n_cmp++;
        if (got != want) begin
            n_bad++;
            $display("FAIL %s: got %0d, required %0d", name, got, want);
        end
    endtask

    // Replay the expected trace: drive on the falling edge, sample 2ns later.
    task automatic exec_q();
        outs_t act;
        for (int i = 0; i < q.size(); i++) begin
            @(negedge clk);
            rst_n     = q[i].rst_n;
            mem_ready = q[i].rdy;
            alu_zero  = q[i].zero;
            opcode    = q[i].op;
            funct     = q[i].fn;
            #2;
            act = {state, mem_req, mem_we, iord, ir_we, pc_we, pc_src, alu_src_a,
                   alu_src_b, alu_cmd, reg_we, reg_dst, wb_src, halted, fault};
            n_cmp++;
            if (act !== q[i].exp) begin
                n_bad++;
                $display("FAIL cycle_%s (op=%0d fn=%0d rst_n=%b rdy=%b): got %h, required %h",
                         sname(q[i].exp.st), cur_op, cur_fn, q[i].rst_n, q[i].rdy,
                         act, q[i].exp);
            end
        end
        q.delete();
    endtask

    initial begin
        logic [5:0] op, fn;
        int         r, wf, wm, ab;

        push_reset();
        push_reset();
        exec_q();

        build(6'd0, 6'd32, 0, 0, 1'b0, 0);  check_int("lat_add", q.size(), 4);  exec_q();
        build(6'd35, 6'd0, 0, 3, 1'b0, 0);  check_int("lat_lw_w3", q.size(), 8); exec_q();
        build(6'd43, 6'd5, 0, 0, 1'b0, 0);  check_int("lat_sw", q.size(), 4);   exec_q();
        build(6'd4, 6'd0, 0, 0, 1'b1, 0);   check_int("lat_beq", q.size(), 3);  exec_q();
        build(6'd4, 6'd0, 0, 0, 1'b0, 0);   exec_q();
        build(6'd5, 6'd0, 0, 0, 1'b1, 0);   exec_q();
        build(6'd5, 6'd0, 0, 0, 1'b0, 0);   exec_q();
        build(6'd0, 6'd8, 1, 0, 1'b0, 0);   check_int("lat_jr_w1", q.size(), 4); exec_q();
        build(6'd3, 6'd0, 0, 0, 1'b0, 0);   exec_q();
        build(6'd8, 6'd0, 3, 0, 1'b0, 0);   check_int("ready_wins", q.size(), 7); exec_q();
        build(6'd9, 6'd0, 0, 0, 1'b0, 0);   exec_q();
        build(6'd10, 6'd0, 2, 0, 1'b0, 0);  exec_q();
        build(6'd0, 6'd32, 6, 0, 1'b0, 0);  check_int("fetch_timeout", q.size(), 8); exec_q();
        build(6'd35, 6'd0, 0, 9, 1'b0, 0);  exec_q();
        build(6'd63, 6'd0, 0, 0, 1'b0, 0);  exec_q();
        build(6'd0, 6'd1, 0, 0, 1'b0, 0);   exec_q();
        build(6'd0, 6'd32, 0, 0, 1'b0, 0);  exec_q();
        build(6'd0, 6'd12, 0, 0, 1'b0, 0);  check_int("halt_trace", q.size(), 23); exec_q();
        build(6'd0, 6'd32, 0, 0, 1'b0, 3);  check_int("abort_exec", q.size(), 4); exec_q();

        for (int n = 0; n < 300; n++) begin
            r = $urandom_range(0, 13);
            fn = 6'($urandom_range(0, 63));
            case (r)
                0:  begin op = 6'd0;  fn = 6'd32; end
                1:  begin op = 6'd0;  fn = 6'd8;  end
                2:  begin op = 6'd0;  fn = 6'd12; end
                3:  op = 6'd3;
                4:  op = 6'd4;
                5:  op = 6'd5;
                6:  op = 6'd8;
                7:  op = 6'd9;
                8:  op = 6'd10;
                9:  op = 6'd35;
                10: op = 6'd43;
                11: op = 6'($urandom_range(0, 63));
                12: op = 6'd0;
                default: op = 6'd35;
            endcase
            wf = ($urandom_range(0, 9) < 8) ? $urandom_range(0, 2) : $urandom_range(3, 5);
            wm = ($urandom_range(0, 9) < 8) ? $urandom_range(0, 2) : $urandom_range(3, 5);
            ab = ($urandom_range(0, 19) == 0) ? $urandom_range(1, 6) : 0;
            build(op, fn, wf, wm, rb(), ab);
            exec_q();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
